// File: rtl/bootstrap_pkg.sv
// Shared types and defaults for the microcode bootstrap writer.
package bootstrap_pkg;

    localparam int BOOT_ADDR_W = 12;
    localparam int BOOT_DATA_W = 8;
    localparam int CHECKSUM_OK = 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SETUP,
        WRITE,
        HOLD,
        WAIT_SUM,
        DONE,
        ERROR
    } boot_state_e;

endpackage

// File: rtl/microcode_bootstrapper.sv
// Streams a boot image into the microcode RAM one byte at a time, then
// verifies the trailing additive checksum before releasing the core.
module microcode_bootstrapper
    import bootstrap_pkg::*;
#(
    parameter int ADDR_W      = BOOT_ADDR_W,
    parameter int DATA_W      = BOOT_DATA_W,
    parameter int IMAGE_BYTES = 4096,
    parameter int WE_CYCLES   = 2
) (
    input  logic              CLK,
    input  logic              N_RST,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [ADDR_W-1:0] BOOTSTRAP_ADDR,
    output logic [DATA_W-1:0] BOOTSTRAP_DATA,
    output logic              BOOTSTRAP_N_WE,
    output logic              N_BOOTED,
    output logic              BOOT_ERROR
);

    localparam int                CNT_W     = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_BYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WE_CYCLES - 1);
    localparam logic [DATA_W-1:0] SUM_OK    = DATA_W'(CHECKSUM_OK);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              nwe_q, nwe_d;
    logic              nbooted_q, nbooted_d;
    logic              error_q, error_d;
    logic              accept;
    logic [DATA_W-1:0] sum_total;

    assign accept    = IN_VALID && ready_q;
    assign sum_total = acc_q + IN_DATA;

    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            nwe_q     <= 1'b1;
            nbooted_q <= 1'b1;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            nwe_q     <= nwe_d;
            nbooted_q <= nbooted_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: state_d = WAIT_BYTE;
            WAIT_BYTE: begin
                if (accept) begin
                    data_d  = IN_DATA;
                    acc_d   = sum_total;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = WRITE;
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // End of image is detected before incrementing, so the address never wraps.
            HOLD: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = WAIT_SUM;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = WAIT_BYTE;
                end
            end
            WAIT_SUM: begin
                if (accept) begin
                    state_d = (sum_total == SUM_OK) ? DONE : ERROR;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe track the next state; boot status lags one edge behind it.
    always_comb begin
        ready_d   = (state_d == WAIT_BYTE) || (state_d == WAIT_SUM);
        nwe_d     = (state_d != WRITE);
        nbooted_d = (state_q != DONE);
        error_d   = (state_q == ERROR);
    end

    assign IN_READY       = ready_q;
    assign BOOTSTRAP_ADDR = addr_q;
    assign BOOTSTRAP_DATA = data_q;
    assign BOOTSTRAP_N_WE = nwe_q;
    assign N_BOOTED       = nbooted_q;
    assign BOOT_ERROR     = error_q;

endmodule

// File: tb/tb_microcode_bootstrapper.sv
// Directed and randomized checks of microcode_bootstrapper against an
// image-level model: writes expected at addresses 0..N-1, checksum sums to zero.
module tb_microcode_bootstrapper;

    localparam int IMG = 4;
    localparam int WEC = 2;

    typedef logic [7:0] img_t [IMG];

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [7:0]  inData = 8'h00;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        nWe;
    logic        nBooted;
    logic        bootErr;

    int errors = 0;
    int checks = 0;

    int          wrAddrQ [$];
    int          wrDataQ [$];
    int          wrLenQ [$];
    bit          inPulse = 1'b0;
    int          pulseLen = 0;
    int          propErr = 0;
    logic [11:0] pAddr = '0;
    logic [7:0]  pData = '0;
    logic [11:0] prevAddr = '0;
    logic [7:0]  prevData = '0;
    logic        prevNWe = 1'b1;

    microcode_bootstrapper #(
        .ADDR_W(12),
        .DATA_W(8),
        .IMAGE_BYTES(IMG),
        .WE_CYCLES(WEC)
    ) dut (
        .CLK(clk),
        .N_RST(nRst),
        .IN_DATA(inData),
        .IN_VALID(inValid),
        .IN_READY(inReady),
        .BOOTSTRAP_ADDR(addr),
        .BOOTSTRAP_DATA(data),
        .BOOTSTRAP_N_WE(nWe),
        .N_BOOTED(nBooted),
        .BOOT_ERROR(bootErr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reconstructs write pulses from the RAM port and flags setup/hold or status violations.
    always @(posedge clk) begin
        #2;
        if (!nWe) begin
            if (!inPulse) begin
                inPulse  = 1'b1;
                pulseLen = 1;
                pAddr    = addr;
                pData    = data;
                if (!prevNWe || addr != prevAddr || data != prevData) propErr++;
            end else begin
                pulseLen++;
                if (addr != pAddr || data != pData) propErr++;
            end
        end else if (inPulse) begin
            inPulse = 1'b0;
            if (nRst && (addr != pAddr || data != pData)) propErr++;
            wrAddrQ.push_back(int'(pAddr));
            wrDataQ.push_back(int'(pData));
            wrLenQ.push_back(pulseLen);
        end
        if (!nBooted && !nWe) propErr++;
        if (!nBooted && bootErr) propErr++;
        prevAddr = addr;
        prevData = data;
        prevNWe  = nWe;
    end

    function automatic logic [7:0] modelChecksum(input img_t img);
        int s = 0;
        foreach (img[i]) s += int'(img[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    function automatic bit modelPass(input img_t img, input logic [7:0] cks);
        int s = int'(cks);
        foreach (img[i]) s += int'(img[i]);
        return (s % 256) == 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearWrites();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrLenQ.delete();
    endtask

    task automatic sendByte(input logic [7:0] b, input string tag);
        bit acc = 1'b0;
        inData  = b;
        inValid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            if (inReady) begin
                @(posedge clk);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput({tag, " accept"}, 32'(acc), 32'd1);
    endtask

    task automatic applyStimulus(input img_t img, input logic [7:0] cks, input int gapMax, input string tag);
        int g;
        clearWrites();
        for (int i = 0; i < IMG; i++) begin
            g = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
            if (g > 0) begin
                inValid = 1'b0;
                repeat (g) @(negedge clk);
            end
            sendByte(img[i], $sformatf("%s b%0d", tag, i));
        end
        sendByte(cks, {tag, " cks"});
        inValid = 1'b0;
    endtask

    task automatic doReset(input int n);
        nRst = 1'b0;
        repeat (n) @(negedge clk);
        nRst = 1'b1;
    endtask

    // Called at the first negedge after the checksum accept edge.
    task automatic verifyLoad(input string tag, input img_t img, input bit pass);
        checkOutput({tag, " nBooted@accept"}, 32'(nBooted), 32'd1);
        @(negedge clk);
        checkOutput({tag, " nBooted"}, 32'(nBooted), pass ? 32'd0 : 32'd1);
        checkOutput({tag, " bootErr"}, 32'(bootErr), pass ? 32'd0 : 32'd1);
        checkOutput({tag, " ready"}, 32'(inReady), 32'd0);
        checkOutput({tag, " nWe"}, 32'(nWe), 32'd1);
        checkOutput({tag, " addr"}, 32'(addr), 32'(IMG - 1));
        checkOutput({tag, " data"}, 32'(data), 32'(img[IMG-1]));
        checkOutput({tag, " wcount"}, 32'(wrAddrQ.size()), 32'(IMG));
        for (int i = 0; i < IMG && i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("%s w%0d addr", tag, i), 32'(wrAddrQ[i]), 32'(i));
            checkOutput($sformatf("%s w%0d data", tag, i), 32'(wrDataQ[i]), 32'(img[i]));
            checkOutput($sformatf("%s w%0d len", tag, i), 32'(wrLenQ[i]), 32'(WEC));
        end
        checkOutput({tag, " props"}, 32'(propErr), 32'd0);
    endtask

    initial begin
        img_t imgA;
        img_t imgB;
        img_t imgR;
        logic [7:0] cks;
        bit pass;
        bit seen;

        imgA = '{8'h11, 8'h22, 8'h33, 8'h44};
        imgB = '{8'hAA, 8'h01, 8'h02, 8'h03};

        // Reset held for 3 cycles, then released
        nRst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst ready", 32'(inReady), 32'd0);
            checkOutput("rst addr", 32'(addr), 32'd0);
            checkOutput("rst data", 32'(data), 32'd0);
            checkOutput("rst nWe", 32'(nWe), 32'd1);
            checkOutput("rst nBooted", 32'(nBooted), 32'd1);
            checkOutput("rst bootErr", 32'(bootErr), 32'd0);
        end
        nRst = 1'b1;
        @(negedge clk);
        checkOutput("rst release ready", 32'(inReady), 32'd1);

        // Good image, valid held high
        applyStimulus(imgA, modelChecksum(imgA), 0, "t1");
        verifyLoad("t1", imgA, modelPass(imgA, modelChecksum(imgA)));

        // Extra bytes after DONE are ignored
        inValid = 1'b1;
        inData  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t5 ready", 32'(inReady), 32'd0);
            checkOutput("t5 nBooted", 32'(nBooted), 32'd0);
            checkOutput("t5 nWe", 32'(nWe), 32'd1);
        end
        checkOutput("t5 wcount", 32'(wrAddrQ.size()), 32'(IMG));
        inValid = 1'b0;

        // Bad checksum
        doReset(1);
        applyStimulus(imgA, 8'h00, 0, "t2");
        verifyLoad("t2", imgA, modelPass(imgA, 8'h00));
        inValid = 1'b1;
        inData  = 8'h56;
        repeat (8) @(negedge clk);
        checkOutput("t2 post ready", 32'(inReady), 32'd0);
        checkOutput("t2 post bootErr", 32'(bootErr), 32'd1);
        checkOutput("t2 post wcount", 32'(wrAddrQ.size()), 32'(IMG));
        inValid = 1'b0;

        // IN_VALID gap of 5 cycles after the first byte
        doReset(1);
        clearWrites();
        sendByte(imgA[0], "t3 b0");
        inValid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = inReady;
        end
        checkOutput("t3 ready reached", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3 gap ready", 32'(inReady), 32'd1);
            checkOutput("t3 gap addr", 32'(addr), 32'd1);
            checkOutput("t3 gap nWe", 32'(nWe), 32'd1);
            @(negedge clk);
        end
        for (int i = 1; i < IMG; i++) sendByte(imgA[i], $sformatf("t3 b%0d", i));
        sendByte(modelChecksum(imgA), "t3 cks");
        inValid = 1'b0;
        verifyLoad("t3", imgA, 1'b1);

        // Reset during the second WRITE cycle of the byte at address 2
        doReset(1);
        clearWrites();
        sendByte(imgA[0], "t4 b0");
        sendByte(imgA[1], "t4 b1");
        sendByte(imgA[2], "t4 b2");
        inValid = 1'b0;
        checkOutput("t4 setup nWe", 32'(nWe), 32'd1);
        @(negedge clk);
        checkOutput("t4 write1 nWe", 32'(nWe), 32'd0);
        @(negedge clk);
        checkOutput("t4 write2 nWe", 32'(nWe), 32'd0);
        checkOutput("t4 write2 addr", 32'(addr), 32'd2);
        nRst = 1'b0;
        @(negedge clk);
        checkOutput("t4 rst nWe", 32'(nWe), 32'd1);
        checkOutput("t4 rst addr", 32'(addr), 32'd0);
        checkOutput("t4 rst ready", 32'(inReady), 32'd0);
        nRst = 1'b1;
        @(negedge clk);
        applyStimulus(imgB, modelChecksum(imgB), 0, "t4r");
        verifyLoad("t4r", imgB, modelPass(imgB, modelChecksum(imgB)));

        // Random images, random valid gaps, random or correct checksums
        for (int t = 0; t < 6; t++) begin
            doReset(1 + int'($urandom_range(0, 2)));
            foreach (imgR[i]) imgR[i] = 8'($urandom);
            cks  = ($urandom_range(0, 1) == 1) ? modelChecksum(imgR) : 8'($urandom);
            pass = modelPass(imgR, cks);
            applyStimulus(imgR, cks, 3, $sformatf("rnd%0d", t));
            verifyLoad($sformatf("rnd%0d", t), imgR, pass);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
